// File: rtl/game_tick_scheduler.sv
// Shared game timebase: one prescaler produces a base tick, and per-channel divisors derive ball and
// paddle clock-enable strobes. These are gated by an IDLE/RUN/SERVE_WAIT/PAUSED state machine.
module game_tick_scheduler #(
  parameter int CLK_HZ       = 50000000,
  parameter int BASE_HZ      = 1000,
  parameter int DIV_W        = 8,
  parameter int BALL_DIV_RST = 10,
  parameter int PAD_DIV_RST  = 5,
  parameter int SERVE_TICKS  = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause_req,
  input  logic             point_scored,
  input  logic             cfg_valid,
  input  logic             cfg_sel,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             base_tick,
  output logic             ball_en,
  output logic             paddle_en,
  output logic             serve_done,
  output logic [1:0]       state
);

  localparam int PRESCALE = CLK_HZ / BASE_HZ;
  localparam int P_W      = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int S_W      = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN        = 2'd1,
    SERVE_WAIT = 2'd2,
    PAUSED     = 2'd3
  } state_t;

  state_t           cur, nxt, ret, ret_nxt;
  logic [P_W-1:0]   p;
  logic [S_W-1:0]   serve_cnt;
  logic [DIV_W-1:0] ball_div, pad_div, ball_cnt, pad_cnt;
  logic             serve_adv, serve_fire, serve_load;
  logic             cfg_wr, ball_adv, pad_adv, ball_clr, pad_clr;

  // A divisor of 0 behaves as 1: the channel fires on every base tick.
  function automatic logic count_done(input logic [DIV_W-1:0] cnt, input logic [DIV_W-1:0] div);
    logic [DIV_W:0] next_cnt;
    next_cnt = {1'b0, cnt} + (DIV_W+1)'(1);
    return (div == '0) || (next_cnt >= {1'b0, div});
  endfunction

  always_comb begin
    nxt        = cur;
    ret_nxt    = ret;
    serve_adv  = 1'b0;
    serve_fire = 1'b0;
    serve_load = 1'b0;
    if (stop) begin
      nxt = IDLE;
    end else begin
      case (cur)
        IDLE:
          if (start) nxt = RUN;
        RUN:
          if (pause_req) begin
            nxt     = PAUSED;
            ret_nxt = RUN;
          end else if (point_scored) begin
            nxt        = SERVE_WAIT;
            serve_load = 1'b1;
          end
        SERVE_WAIT:
          if (pause_req) begin
            nxt     = PAUSED;
            ret_nxt = SERVE_WAIT;
          end else if (base_tick) begin
            serve_adv = 1'b1;
            if (serve_cnt == S_W'(SERVE_TICKS - 1)) begin
              nxt        = RUN;
              serve_fire = 1'b1;
            end
          end
        PAUSED:
          if (!pause_req) nxt = ret;
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur        <= IDLE;
      ret        <= RUN;
      serve_cnt  <= '0;
      serve_done <= 1'b0;
    end else begin
      cur        <= nxt;
      ret        <= ret_nxt;
      serve_done <= serve_fire;
      if (serve_load || stop)
        serve_cnt <= '0;
      else if (serve_fire)
        serve_cnt <= '0;
      else if (serve_adv)
        serve_cnt <= serve_cnt + S_W'(1);
    end
  end

  // Prescaler: held at zero in IDLE, frozen while paused.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      p         <= '0;
      base_tick <= 1'b0;
    end else if (stop || cur == IDLE) begin
      p         <= '0;
      base_tick <= 1'b0;
    end else if (cur == PAUSED) begin
      base_tick <= 1'b0;
    end else begin
      base_tick <= (p == P_W'(PRESCALE - 1));
      p         <= (p == P_W'(PRESCALE - 1)) ? '0 : p + P_W'(1);
    end
  end

  assign cfg_ready = (cur == IDLE) || (cur == PAUSED);
  assign cfg_wr    = cfg_valid && cfg_ready;
  assign ball_adv  = base_tick && (cur == RUN);
  assign pad_adv   = base_tick && ((cur == RUN) || (cur == SERVE_WAIT));
  assign ball_clr  = stop || (cur == IDLE) || serve_load || (cfg_wr && !cfg_sel);
  assign pad_clr   = stop || (cur == IDLE) || (cfg_wr && cfg_sel);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ball_div  <= DIV_W'(BALL_DIV_RST);
      pad_div   <= DIV_W'(PAD_DIV_RST);
      ball_cnt  <= '0;
      pad_cnt   <= '0;
      ball_en   <= 1'b0;
      paddle_en <= 1'b0;
    end else begin
      ball_en   <= 1'b0;
      paddle_en <= 1'b0;
      if (cfg_wr && !cfg_sel) ball_div <= cfg_div;
      if (cfg_wr && cfg_sel)  pad_div  <= cfg_div;

      if (ball_clr) begin
        ball_cnt <= '0;
      end else if (ball_adv) begin
        if (count_done(ball_cnt, ball_div)) begin
          ball_cnt <= '0;
          ball_en  <= 1'b1;
        end else begin
          ball_cnt <= ball_cnt + DIV_W'(1);
        end
      end

      if (pad_clr) begin
        pad_cnt <= '0;
      end else if (pad_adv) begin
        if (count_done(pad_cnt, pad_div)) begin
          pad_cnt   <= '0;
          paddle_en <= 1'b1;
        end else begin
          pad_cnt <= pad_cnt + DIV_W'(1);
        end
      end
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler: PRESCALE=10, SERVE_TICKS=3, ball divisor 2, paddle divisor 1.
module tb_game_tick_scheduler;
  logic       clock = 1'b0;
  logic       reset, start, stop, pause_req, point_scored, cfg_valid, cfg_sel;
  logic [7:0] cfg_div;
  logic       cfg_ready, base_tick, ball_en, paddle_en, serve_done;
  logic [1:0] state;
  int         checks = 0;
  int         errors = 0;

  game_tick_scheduler #(
    .CLK_HZ(100), .BASE_HZ(10), .DIV_W(8),
    .BALL_DIV_RST(2), .PAD_DIV_RST(1), .SERVE_TICKS(3)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .pause_req(pause_req),
    .point_scored(point_scored), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .base_tick(base_tick), .ball_en(ball_en), .paddle_en(paddle_en),
    .serve_done(serve_done), .state(state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {serve_done, base_tick, paddle_en, ball_en}
  function automatic logic [31:0] strobes();
    return {28'd0, serve_done, base_tick, paddle_en, ball_en};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic cfg_write(input logic sel, input logic [7:0] div);
    cfg_valid = 1'b1;
    cfg_sel   = sel;
    cfg_div   = div;
    step();
    cfg_valid = 1'b0;
  endtask

  // Plain RUN window: cycle c counts from the edge that sampled start (c=0).
  task automatic run_window(input string tag, input int c0, input int c1,
                            input int bp, input int pp, input int cfg_at);
    logic [31:0] e;
    for (int c = c0; c <= c1; c++) begin
      step();
      if (c == cfg_at + 1) cfg_valid = 1'b0;
      e    = '0;
      e[2] = (c % 10 == 0);
      e[1] = (c > 1) && (c % (10 * pp) == 1);
      e[0] = (c > 1) && (c % (10 * bp) == 1);
      check($sformatf("%s_c%0d", tag, c), strobes(), e);
      if (c == c1) check($sformatf("%s_state", tag), 32'(state), 32'd1);
      if (c == cfg_at) begin
        check($sformatf("%s_ready_run", tag), 32'(cfg_ready), 32'd0);
        cfg_valid = 1'b1;
        cfg_sel   = 1'b0;
        cfg_div   = 8'd1;
      end
    end
  endtask

  initial begin
    logic [31:0] e;
    int          es;
    reset = 1'b1; start = 1'b0; stop = 1'b0; pause_req = 1'b0; point_scored = 1'b0;
    cfg_valid = 1'b0; cfg_sel = 1'b0; cfg_div = 8'd0;
    step(); step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_strobes", strobes(), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    reset = 1'b0;
    step(); step();
    check("idle_state", 32'(state), 32'd0);
    check("idle_strobes", strobes(), 32'd0);

    // Default divisors from reset.
    pulse_start();
    check("t1_state0", 32'(state), 32'd1);
    run_window("t1", 1, 45, 2, 1, -1);

    // Ball divisor 3 written in IDLE; a write attempted in RUN is ignored.
    do_stop();
    check("t2_stop_state", 32'(state), 32'd0);
    check("t2_stop_strobes", strobes(), 32'd0);
    cfg_write(1'b0, 8'd3);
    pulse_start();
    run_window("t2", 1, 95, 3, 1, 66);

    // Point scored at cycle 15: serve wait of three ticks, ball counter cleared.
    do_stop();
    cfg_write(1'b0, 8'd2);
    pulse_start();
    for (int c = 1; c <= 65; c++) begin
      step();
      if (c == 16) point_scored = 1'b0;
      e    = '0;
      e[3] = (c == 41);
      e[2] = (c % 10 == 0);
      e[1] = (c > 1) && (c % 10 == 1);
      e[0] = (c == 61);
      check($sformatf("t3_c%0d", c), strobes(), e);
      es = (c < 16) ? 1 : (c < 41) ? 2 : 1;
      check($sformatf("t3_state_c%0d", c), 32'(state), 32'(es));
      if (c == 15) point_scored = 1'b1;
    end

    // Pause for 50 cycles after the first serve tick.
    do_stop();
    pulse_start();
    for (int c = 1; c <= 105; c++) begin
      step();
      if (c == 6) point_scored = 1'b0;
      e    = '0;
      e[3] = (c == 81);
      e[2] = (c == 10) || (c >= 70 && c % 10 == 0);
      e[1] = (c == 11) || (c >= 71 && c % 10 == 1);
      e[0] = (c == 101);
      check($sformatf("t4_c%0d", c), strobes(), e);
      es = (c < 6) ? 1 : (c < 13) ? 2 : (c < 63) ? 3 : (c < 81) ? 2 : 1;
      check($sformatf("t4_state_c%0d", c), 32'(state), 32'(es));
      if (c == 5)  point_scored = 1'b1;
      if (c == 12) pause_req = 1'b1;
      if (c == 62) pause_req = 1'b0;
    end

    // stop with pause_req on the cycle a base tick is due.
    do_stop();
    pulse_start();
    run_window("t5a", 1, 9, 2, 1, -1);
    stop = 1'b1; pause_req = 1'b1;
    step();
    stop = 1'b0; pause_req = 1'b0;
    check("t5_stop_state", 32'(state), 32'd0);
    check("t5_stop_strobes", strobes(), 32'd0);
    step();
    check("t5_idle_strobes", strobes(), 32'd0);
    pulse_start();
    run_window("t5b", 1, 10, 2, 1, -1);
    reset = 1'b1;
    #1;
    check("t5_areset_state", 32'(state), 32'd0);
    check("t5_areset_strobes", strobes(), 32'd0);
    check("t5_areset_ready", 32'(cfg_ready), 32'd1);
    step();
    reset = 1'b0;
    step();
    check("t5_post_reset_state", 32'(state), 32'd0);

    // Ball divisor 0 behaves as 1; paddle divisor 2.
    cfg_write(1'b0, 8'd0);
    cfg_write(1'b1, 8'd2);
    pulse_start();
    run_window("t6", 1, 45, 1, 2, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
